// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch sequencer: opcodes, jump modes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   // j/jal target formation
   localparam int JUMP_MODE_ZEXT = 0;   // zero-extended instr[25:0] as a byte address
   localparam int JUMP_MODE_MIPS = 1;   // {pc_plus4[top:28], target26, 2'b00}

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      EXEC  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC selection: jr > jump > taken branch > sequential, plus misalignment flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is consumed.
module mips_next_pc
   import mips_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int JUMP_MODE = JUMP_MODE_ZEXT
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       instr,
   input  logic              branch,
   input  logic              bne,
   input  logic              zero,
   input  logic              jump,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] next_pc,
   output logic              misaligned
);

   // Bits 27:0 of a standard MIPS jump come from the instruction, the rest from pc_plus4
   localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

   logic [ADDR_W-1:0] pc_plus4;
   logic [31:0]       off32;
   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] jump_tgt;
   logic              taken;
   logic              unused_opcode;

   assign unused_opcode = ^instr[31:26];

   assign pc_plus4   = pc + ADDR_W'(4);
   assign off32      = {{14{instr[15]}}, instr[15:0], 2'b00};
   // Signed cast keeps backward offsets correct for any ADDR_W; wrap is modulo 2^ADDR_W
   assign branch_tgt = pc_plus4 + ADDR_W'($signed(off32));
   assign taken      = branch & (bne ? ~zero : zero);

   // Target formation and priority select
   always_comb begin
      jump_tgt = ADDR_W'(instr[25:0]);
      if (JUMP_MODE == JUMP_MODE_MIPS) begin
         jump_tgt = (pc_plus4 & ~LOW28_MASK) | ADDR_W'({instr[25:0], 2'b00});
      end

      next_pc = pc_plus4;
      if (jr) begin
         next_pc = jr_target;
      end else if (jump) begin
         next_pc = jump_tgt;
      end else if (taken) begin
         next_pc = branch_tgt;
      end
   end

   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/mips_fetch_sequencer.sv
// PC owner and fetch sequencer: fetch over a ready handshake, hold until retired, select next PC.
// Latency: 2 cycles per instruction minimum (REQ + EXEC); first request in the second cycle after reset.
// Backpressure: imem_ready=0 holds REQ indefinitely; stall=1 holds EXEC with no side effects.
module mips_fetch_sequencer
   import mips_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                JUMP_MODE = JUMP_MODE_ZEXT,
   parameter int                CNT_W     = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              stall,
   input  logic              branch,
   input  logic              bne,
   input  logic              zero,
   input  logic              jump,
   input  logic              jal,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_data,
   output logic              fault,
   output logic [CNT_W-1:0]  retired
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] next_pc;
   logic              misaligned;
   logic              retire;

   assign imem_addr = pc;
   assign pc_plus4  = pc + ADDR_W'(4);
   assign retire    = (state == EXEC) && !stall;

   mips_next_pc #(
      .ADDR_W    (ADDR_W),
      .JUMP_MODE (JUMP_MODE)
   ) u_next_pc (
      .pc         (pc),
      .instr      (instr),
      .branch     (branch),
      .bne        (bne),
      .zero       (zero),
      .jump       (jump),
      .jr         (jr),
      .jr_target  (jr_target),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   // FSM state register; reset always returns to the priming cycle
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         BOOT: state_nxt = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_ready) state_nxt = EXEC;
         end
         EXEC: begin
            instr_valid = 1'b1;
            if (!stall) state_nxt = misaligned ? FAULT : REQ;
         end
         FAULT: state_nxt = FAULT;
         default: state_nxt = BOOT;
      endcase
   end

   // Instruction capture, PC update, retirement counter, link pulse and sticky fault
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc        <= RESET_PC;
         instr     <= '0;
         retired   <= '0;
         link_data <= '0;
         link_we   <= 1'b0;
         fault     <= 1'b0;
      end else begin
         link_we <= 1'b0;
         if (state == REQ && imem_ready) begin
            instr <= imem_rdata;
         end
         if (retire) begin
            // A misaligned target is still loaded so debug can see the offending value
            pc      <= next_pc;
            retired <= retired + CNT_W'(1);
            if (misaligned) begin
               fault <= 1'b1;
            end
            if (jal && !jr) begin
               link_we   <= 1'b1;
               link_data <= pc_plus4;
            end
         end
      end
   end

endmodule
